running_mean_window: RTL
========================

// Module: running_mean_window
// PURPOSE
//  Sliding-window running mean over the last 2**WIN_LOG2 signed samples; upstream stage of the spike threshold comparator.
//  Emits each accepted sample together with the window mean that includes it, aligned in the same cycle.
//  Downstream compares |out_sample - out_mean| against its threshold, so both outputs must be cycle-aligned.
// PARAMETERS
//  DW        32  sample/mean width, signed two's complement
//  WIN_LOG2  4   log2 of window length N (N = 16); legal range 1..8
// PORTS
//  clk         in   1         single clock, rising edge
//  rst_n       in   1         asynchronous, active-low reset
//  clr         in   1         synchronous flush: empty window, zero sum
//  in_valid    in   1         in_sample is accepted this cycle (no backpressure)
//  in_sample   in   DW        signed input sample
//  out_valid   out  1         one-cycle pulse: out_sample/out_mean updated
//  out_sample  out  DW        registered copy of the accepted sample (X to comparator)
//  out_mean    out  DW        signed window mean incl. that sample (M to comparator)
//  win_full    out  1         high once N samples accepted since reset/clr
// BEHAVIOUR
//  - Reset (rst_n=0, async): out_valid=0, out_sample=0, out_mean=0, win_full=0, sum=0, wr_ptr=0, fill count=0.
//    Ring storage contents are NOT reset; the fill count masks stale entries.
//  - Accept (in_valid=1, clr=0): old = win_full ? ring[wr_ptr] : 0
//    sum <= sum + in_sample - old; ring[wr_ptr] <= in_sample; wr_ptr <= wr_ptr+1 (wraps mod N).
//    count saturates at N; win_full <= 1 when count reaches N.
//  - Latency: 1 cycle. Sample accepted in cycle t gives out_valid=1 in t+1, with out_sample=that sample
//    and out_mean=(new sum)>>>WIN_LOG2.
//  - out_valid=0 on cycles with no accept; out_sample/out_mean then hold their last values.
//  - Arithmetic: sum is DW+WIN_LOG2 bits signed, so it cannot overflow.
//    Mean is an arithmetic shift (floor toward -inf) truncated to DW bits; always in range.
//  - Warm-up (count<N): the divisor is still N, i.e. missing entries count as 0 (mean ramps up).
//    Downstream gates spike detection with win_full.
//  - clr=1: next cycle sum=0, count=0, win_full=0, wr_ptr=0, out_valid=0; out_sample/out_mean hold.
//    clr together with in_valid: clr wins; the sample is dropped (no out_valid).
//  - Back-to-back in_valid every cycle: full throughput, one output per input, no bubbles.
//  - Read-before-write on the same ring slot in one cycle: old must be the pre-write value.
//  - rst_n asserted mid-stream: all state returns to reset values immediately.
//    The first post-reset output treats the window as empty.
// STRUCTURE
//  - Shared package (spike_pkg): DW default, WIN_LOG2 default, derived SUM_W = DW+WIN_LOG2,
//    typedef for the signed sample type.
//  - One sub-module: sample_ring. It holds N x DW storage, the wr_ptr register, and a combinational
//    read of the oldest entry, with write on accept. The top holds sum, count, win_full and the output registers.
//  - No FSM beyond the fill counter (states FILLING -> FULL; FULL -> FILLING only via clr/reset).
// TESTING  (bench uses WIN_LOG2=2, N=4, DW=32)
//  1 rst_n low then high; feed 4,8,12,16 on consecutive cycles -> out_mean 1,3,6,10 (each 1 cycle later);
//    win_full rises with the 4th output.
//  2 continue with 20, then 24 -> out_mean 14, 18 (oldest entries 4 and 8 evicted); out_sample 20, 24.
//  3 after reset, feed -5 -> out_mean -2 (floor: -5>>>2); then feed -3 -> sum -8, out_mean -2.
//  4 fill with 0x7FFFFFFF x4 -> out_mean 0x7FFFFFFF; then 0x80000000 x4 -> last out_mean 0x80000000, no overflow.
//  5 full window, assert clr together with in_valid=1, sample 100 -> no out_valid, win_full=0.
//    Next feed 8 -> out_mean 2.
//  6 in_valid gaps (1 of every 3 cycles) -> out_valid pulses only after accepts; outputs hold in between.
//    Assert rst_n mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/spike_pkg.sv
// Shared widths and types for the spike-detection front end.
package spike_pkg;

   localparam int unsigned DW_DEF       = 32;
   localparam int unsigned WIN_LOG2_DEF = 4;
   localparam int unsigned SUM_W_DEF    = DW_DEF + WIN_LOG2_DEF;

   typedef logic signed [DW_DEF-1:0] sample_t;

endpackage : spike_pkg

// File: rtl/sample_ring.sv
// Circular store of the last 2**WIN_LOG2 samples; exposes the entry about to be overwritten.
module sample_ring
   import spike_pkg::*;
#(
   parameter int unsigned DW       = DW_DEF,
   parameter int unsigned WIN_LOG2 = WIN_LOG2_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr_i,
   input  logic                 wr_en_i,
   input  logic signed [DW-1:0] wr_data_i,
   output logic signed [DW-1:0] oldest_c_o
);

   localparam int unsigned N = 1 << WIN_LOG2;

   logic signed [DW-1:0]  mem_q [N];
   logic [WIN_LOG2-1:0]   wr_ptr_q;
   logic [WIN_LOG2-1:0]   wr_ptr_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      if (clr_i) begin
         wr_ptr_d = '0;
      end else if (wr_en_i) begin
         wr_ptr_d = wr_ptr_q + WIN_LOG2'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
      end
   end

   // Storage is deliberately unreset; the fill count in the parent masks stale slots.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   // Read happens before this cycle's write lands, so the evicted value is the pre-write one.
   assign oldest_c_o = mem_q[wr_ptr_q];

endmodule : sample_ring

// File: rtl/running_mean_window.sv
// Sliding-window running mean; emits each accepted sample with the mean that includes it.
module running_mean_window
   import spike_pkg::*;
#(
   parameter int unsigned DW       = DW_DEF,
   parameter int unsigned WIN_LOG2 = WIN_LOG2_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic                 in_valid,
   input  logic signed [DW-1:0] in_sample,
   output logic                 out_valid,
   output logic signed [DW-1:0] out_sample,
   output logic signed [DW-1:0] out_mean,
   output logic                 win_full
);

   localparam int unsigned N     = 1 << WIN_LOG2;
   localparam int unsigned SUM_W = DW + WIN_LOG2;
   localparam int unsigned CNT_W = WIN_LOG2 + 1;

   logic signed [SUM_W-1:0] sum_q, sum_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic                    win_full_q, win_full_d;
   logic                    out_valid_q, out_valid_d;
   logic signed [DW-1:0]    out_sample_q, out_sample_d;
   logic signed [DW-1:0]    out_mean_q, out_mean_d;
   logic signed [DW-1:0]    oldest_c;
   logic signed [DW-1:0]    old_c;
   logic                    accept_c;

   assign accept_c = in_valid & ~clr;

   sample_ring #(
      .DW       (DW),
      .WIN_LOG2 (WIN_LOG2)
   ) u_ring (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (clr),
      .wr_en_i    (accept_c),
      .wr_data_i  (in_sample),
      .oldest_c_o (oldest_c)
   );

   // During warm-up the missing entries count as zero.
   assign old_c = win_full_q ? oldest_c : '0;

   always_comb begin
      sum_d        = sum_q;
      count_d      = count_q;
      win_full_d   = win_full_q;
      out_valid_d  = 1'b0;
      out_sample_d = out_sample_q;
      out_mean_d   = out_mean_q;
      if (clr) begin
         sum_d      = '0;
         count_d    = '0;
         win_full_d = 1'b0;
      end else if (in_valid) begin
         sum_d        = sum_q + SUM_W'(in_sample) - SUM_W'(old_c);
         if (count_q != CNT_W'(N)) begin
            count_d = count_q + CNT_W'(1);
         end
         win_full_d   = win_full_q | (count_q == CNT_W'(N - 1));
         out_valid_d  = 1'b1;
         out_sample_d = in_sample;
         out_mean_d   = DW'(sum_d >>> WIN_LOG2);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q        <= '0;
         count_q      <= '0;
         win_full_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         out_sample_q <= '0;
         out_mean_q   <= '0;
      end else begin
         sum_q        <= sum_d;
         count_q      <= count_d;
         win_full_q   <= win_full_d;
         out_valid_q  <= out_valid_d;
         out_sample_q <= out_sample_d;
         out_mean_q   <= out_mean_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_sample = out_sample_q;
   assign out_mean   = out_mean_q;
   assign win_full   = win_full_q;

endmodule : running_mean_window
